// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int  j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter between NREQ byte sources.
//
// state | meaning
// IDLE  | no owner; pick next requester from rr pointer
// SEND  | owner holds the UART; strobe when its byte is valid and UART not busy
// GAP   | one cycle after a write while UART busy rises; release if byte was last
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   uart_wr,
    output logic [BYTE_W-1:0]      uart_dat,
    input  logic                   uart_busy,
    output logic [NREQ-1:0]        grant,
    output logic                   timeout_evt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   rr;
    logic [TW-1:0]   cnt;
    logic            last_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   rr_next;
    logic            g_valid;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req (req_valid),
        .ptr (rr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign g_valid   = req_valid[gidx];
    assign uart_wr   = (state == SEND) && g_valid && !uart_busy;
    assign uart_dat  = (grant != '0) ? req_data[gidx*BYTE_W +: BYTE_W] : '0;
    assign req_ready = uart_wr ? grant : '0;
    assign rr_next   = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            gidx        <= '0;
            rr          <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid != '0) begin
                        grant <= pick_gnt;
                        gidx  <= pick_idx;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (uart_wr) begin
                        last_q <= req_last[gidx];
                        cnt    <= '0;
                        state  <= GAP;
                    end else if (!g_valid) begin
                        // Stalled owner: counter saturates at TIMEOUT-1 and drops the lock there.
                        if (cnt == TW'(TIMEOUT-1)) begin
                            timeout_evt <= 1'b1;
                            rr          <= rr_next;
                            grant       <= '0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (last_q) begin
                        rr    <= rr_next;
                        grant <= '0;
                        state <= IDLE;
                    end else begin
                        state <= SEND;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a UART busy model drive it,
// a negedge monitor checks every write against hand-ordered expectations.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        uart_wr;
    logic [7:0]  uart_dat;
    logic        uart_busy;
    logic [3:0]  grant;
    logic        timeout_evt;

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT(8), .TW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .uart_wr     (uart_wr),
        .uart_dat    (uart_dat),
        .uart_busy   (uart_busy),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] src_q[4][$];
    int         wr_log[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         evt_count = 0;
    int         evt_cyc = 0;
    int         busy_len = 10;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;
    logic [3:0] took;
    logic       wr_seen;
    logic [8:0] hd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic src_push(input int i, input logic [7:0] d, input logic last);
        src_q[i].push_back({last, d});
    endtask

    task automatic exp_push(input logic [1:0] i, input logic [7:0] d);
        exp_q.push_back({i, d});
    endtask

    function automatic logic all_src_empty();
        return src_q[0].size() == 0 && src_q[1].size() == 0 &&
               src_q[2].size() == 0 && src_q[3].size() == 0;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && grant == 4'b0 && all_src_empty() && busy_cnt == 0)
                done = 1'b1;
        end
        check(name, {31'b0, done}, 32'd1);
    endtask

    // Requester sources and UART busy model; inputs change 1 time unit after posedge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            took    = req_ready;
            wr_seen = uart_wr;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (took[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    hd = src_q[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = hd[7:0];
                    req_last[i]        = hd[8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            if (wr_seen) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            uart_busy = force_busy || (busy_cnt > 0);
        end
    end

    // Monitor: every UART strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] eg;
        if (!reset) begin
            total++;
            if (!$onehot0(grant)) begin
                bad++;
                $display("FAIL grant_onehot got=%b exp=onehot0", grant);
            end
            if (timeout_evt) begin
                evt_count++;
                evt_cyc = cyc;
            end
            if (uart_wr) begin
                wr_log.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write got=%0d:%02h exp=none", grant, uart_dat);
                end else begin
                    e  = exp_q.pop_front();
                    eg = 4'b0001 << e.idx;
                    if (grant !== eg || uart_dat !== e.data || req_ready !== eg || uart_busy) begin
                        bad++;
                        $display("FAIL write got=g%b d%02h r%b b%b exp=g%b d%02h r%b b0",
                                 grant, uart_dat, req_ready, uart_busy, eg, e.data, eg);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_grant", {28'b0, grant}, 32'd0);
        check("reset_wr", {31'b0, uart_wr}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int evt0;
        int stuck;
        logic seen_free;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", {28'b0, grant}, 32'd0);
        check("rst_wr", {31'b0, uart_wr}, 32'd0);
        check("rst_ready", {28'b0, req_ready}, 32'd0);
        check("rst_evt", {31'b0, timeout_evt}, 32'd0);
        check("rst_dat", {24'b0, uart_dat}, 32'd0);
        reset = 1'b0;

        // Single requester, 3-byte message, UART busy 10 cycles per byte.
        busy_len = 10;
        base = wr_log.size();
        src_push(0, 8'h41, 1'b0); src_push(0, 8'h42, 1'b0); src_push(0, 8'h43, 1'b1);
        exp_push(0, 8'h41); exp_push(0, 8'h42); exp_push(0, 8'h43);
        wait_idle("single_idle", 300);
        check("single_grant_end", {28'b0, grant}, 32'd0);
        check("single_gap01", wr_log[base+1] - wr_log[base], 32'd11);
        check("single_gap12", wr_log[base+2] - wr_log[base+1], 32'd11);

        // rr now points at 1: req1 must beat req0.
        busy_len = 3;
        src_push(0, 8'h50, 1'b1); src_push(1, 8'h60, 1'b1);
        exp_push(1, 8'h60); exp_push(0, 8'h50);
        wait_idle("rr_after_single", 200);

        // Contention from rr=0: req0 message completes before req2 starts.
        apply_reset();
        busy_len = 4;
        src_push(0, 8'h10, 1'b0); src_push(0, 8'h11, 1'b1);
        src_push(2, 8'h30, 1'b0); src_push(2, 8'h31, 1'b1);
        exp_push(0, 8'h10); exp_push(0, 8'h11); exp_push(2, 8'h30); exp_push(2, 8'h31);
        wait_idle("contention_idle", 300);

        // Fairness: two single-byte messages per requester, strict rotation.
        apply_reset();
        busy_len = 3;
        for (int i = 0; i < 4; i++) begin
            src_push(i, 8'hA0 + 8'(i), 1'b1);
            src_push(i, 8'hB0 + 8'(i), 1'b1);
        end
        for (int i = 0; i < 4; i++) exp_push(2'(i), 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) exp_push(2'(i), 8'hB0 + 8'(i));
        wait_idle("fair_idle", 400);

        // Timeout: req1 stalls after one non-last byte, req3 waits and then gets the UART.
        base = wr_log.size();
        evt0 = evt_count;
        src_push(1, 8'h71, 1'b0);
        src_push(3, 8'h73, 1'b0); src_push(3, 8'h74, 1'b1);
        exp_push(1, 8'h71); exp_push(3, 8'h73); exp_push(3, 8'h74);
        wait_idle("timeout_idle", 300);
        check("timeout_pulses", evt_count - evt0, 32'd1);
        // write at w, GAP w+1, 8 stalled SEND cycles, pulse visible at w+10
        check("timeout_delay", evt_cyc - wr_log[base], 32'd10);
        check("timeout_next_wr", wr_log[base+1] - evt_cyc, 32'd1);

        // Busy backpressure: 50 busy cycles, no strobe, no timeout.
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        evt0 = evt_count;
        stuck = 0;
        src_push(0, 8'h5A, 1'b1);
        exp_push(0, 8'h5A);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (uart_wr || req_ready != 4'b0) stuck++;
        end
        check("busy_no_write", stuck, 32'd0);
        check("busy_no_timeout", evt_count - evt0, 32'd0);
        check("busy_grant", {28'b0, grant}, 32'h1);
        force_busy = 1'b0;
        seen_free = 1'b0;
        for (int k = 0; k < 5 && !seen_free; k++) begin
            @(negedge clk);
            if (!uart_busy) seen_free = 1'b1;
        end
        check("busy_release_seen", {31'b0, seen_free}, 32'd1);
        check("busy_first_free_wr", {31'b0, uart_wr}, 32'd1);
        wait_idle("busy_idle", 100);

        // Reset mid-message: req2 (rr=1) holds the UART, reset hits during its second byte.
        busy_len = 10;
        base = wr_log.size();
        src_push(2, 8'h21, 1'b0); src_push(2, 8'h22, 1'b0); src_push(2, 8'h23, 1'b1);
        src_push(0, 8'h01, 1'b1);
        exp_push(2, 8'h21);
        for (int k = 0; k < 50 && wr_log.size() == base; k++) @(negedge clk);
        check("midrst_first_wr", wr_log.size() - base, 32'd1);
        repeat (3) @(negedge clk);
        check("midrst_grant_before", {28'b0, grant}, 32'h4);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_grant", {28'b0, grant}, 32'd0);
        check("midrst_wr", {31'b0, uart_wr}, 32'd0);
        check("midrst_ready", {28'b0, req_ready}, 32'd0);
        reset = 1'b0;
        exp_push(0, 8'h01); exp_push(2, 8'h22); exp_push(2, 8'h23);
        wait_idle("midrst_idle", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NREQ byte-stream requesters using round-robin arbitration.
- Arbitration happens at message granularity. A requester that wins the grant keeps the transmitter until it sends a byte flagged last, or until it stalls for longer than TIMEOUT cycles.
- Sits between the CPU/debug/trace byte sources and the transmit side of the UART: drives its write strobe and data, and watches its busy flag.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, idle cycles mid-message after which the lock is released (>=2).
- TW, 16, width of the timeout counter; 2**TW > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte offered.
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i].
- req_last  in  NREQ  offered byte is the final byte of its message.
- req_ready  out  NREQ  byte of requester i is accepted this cycle.
- uart_wr  out  1  write strobe to the UART transmitter.
- uart_dat  out  8  data to the UART transmitter.
- uart_busy  in  1  UART transmitter is shifting.
- grant  out  NREQ  one-hot owner of the transmitter; zero when idle.
- timeout_evt  out  1  one-cycle pulse when a lock is dropped by timeout.

Behaviour:
- Reset (sync, reset=1 at posedge): state=IDLE, grant=0, rr pointer=0, timeout counter=0, timeout_evt=0. With grant=0, uart_wr=0 and req_ready=0. uart_dat=0 while idle.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from pointer rr upward (modulo NREQ). Load grant one-hot, clear the counter, go to SEND.
  - No byte is sent in the IDLE cycle, so grant-to-first-write latency is 1 cycle.
- SEND (g = granted index):
  - uart_wr = req_valid[g] & ~uart_busy, combinational. uart_dat = req_data[g] is muxed whenever grant is nonzero. req_ready[g] = uart_wr. All other req_ready bits are 0.
  - On accept (uart_wr=1): go to GAP and clear the counter.
  - Without accept: if req_valid[g]=0, the counter increments; if uart_busy=1, it is held. When the counter reaches TIMEOUT-1 with req_valid[g]=0: pulse timeout_evt, set rr = g+1 mod NREQ, grant=0, go to IDLE.
- GAP:
  - Exactly one cycle. It covers the UART busy flag rising one cycle after the write. uart_wr=0 in this cycle.
  - If the accepted byte had req_last=1 (registered at accept): rr = g+1 mod NREQ, grant=0, go to IDLE.
  - Otherwise return to SEND with grant unchanged.
- Back-to-back throughput is limited by the UART. In SEND the arbiter waits for uart_busy=0, so no byte is ever dropped.
- The uart_wr & ~uart_busy condition guarantees that every strobe is accepted by the transmitter.
- A requester dropping req_valid mid-message keeps its lock until TIMEOUT. Other requesters wait.
- A single-byte message (last on the first byte) releases the lock immediately after its GAP.
- If req_last is sent together with a timeout condition, the accept wins: the counter only runs when req_valid[g]=0.
- req_data and req_last of non-granted requesters are ignored. Requesters must hold data stable while valid and not ready.
- Reset asserted mid-message takes effect at the next posedge: grant and uart_wr are 0 the following cycle. A byte already handed to the UART completes under the UART's own control.
- Counter width is TW bits with no wrap: it saturates at TIMEOUT-1 and the transition fires there.
- grant is always zero or one-hot.

Decomposition:
- Shared package uart_pkg: state encoding constants (IDLE, SEND, GAP) and the byte width constant 8.
- One natural sub-module: rr_pick. It is combinational: NREQ-bit request vector plus pointer in, one-hot grant plus index out. It is reused by other arbiters in the SoC.
- Data mux and timeout counter stay inline.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43; UART model busy 10 cycles per byte. Expect 3 uart_wr pulses in order, each when busy=0, grant back to 0 after the third GAP, rr=1.
- Contention: req0 and req2 each offer 2-byte messages at reset release. Expect grant=0001 first, both req0 bytes before any req2 byte, then grant=0100. No interleaving on uart_dat.
- Fairness: all 4 requesters continuously offer 1-byte messages. Expect grant sequence 0,1,2,3,0,1 across 6 messages.
- Timeout with TIMEOUT=8: req1 sends 1 non-last byte then drops valid, while req3 is valid. Expect timeout_evt pulse 8 cycles after GAP, then grant=1000 and req3 bytes sent.
- Busy backpressure: UART busy held high 50 cycles while req0 is valid. Expect uart_wr=0, req_ready=0 and no timeout throughout. Write occurs in the first cycle busy=0.
- Reset mid-message: assert reset during SEND of req2's second byte. Expect grant=0, uart_wr=0, rr=0 the next cycle, then normal arbitration from requester 0.
